// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3), one conversion per start request.
// Optional leading-zero mask output o_blank is built when BCD_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int W_IN     = 16,
    parameter int N_DIGITS = 5
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [W_IN-1:0]       i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*N_DIGITS-1:0] o_bcd,
    output logic                  o_ovf,
`ifdef BCD_BLANK_EN
    output logic [N_DIGITS-1:0]   o_blank,
`endif
    output logic [1:0]            o_dbg_state
);

    // Handshake: i_start is a request sampled only in IDLE, together with i_bin; it is
    // ignored while busy or in DONE. o_done pulses for exactly one cycle, in the same
    // cycle that o_bcd/o_ovf first show the new result; they then hold until the next pulse.

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(W_IN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W_IN-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_int_q, ovf_int_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   scr_adj;
    logic [BCD_W-1:0]   scr_shift;
    logic [BCD_W-1:0]   all_nines;
    logic               carry_out;
    logic               ovf_next;
    logic               last_shift;

`ifdef BCD_BLANK_EN
    logic [N_DIGITS-1:0] blank_q, blank_d;

    // Bit k set when digits k..top are all zero; bit 0 stays clear so a lone zero is shown.
    function automatic logic [N_DIGITS-1:0] blank_of(input logic [BCD_W-1:0] bcd);
        logic zero_run;
        blank_of = '0;
        zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run & (bcd[4*k +: 4] == 4'd0);
            blank_of[k] = zero_run;
        end
    endfunction
`endif

    // Per-digit add-3 adjust; nibbles are independent, nothing carries between them.
    always_comb begin
        scr_adj = scr_q;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                scr_adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        all_nines = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            all_nines[4*k +: 4] = 4'h9;
        end
    end

    // A set bit leaving the top digit means the value no longer fits in N_DIGITS.
    assign carry_out  = scr_adj[BCD_W-1];
    assign scr_shift  = {scr_adj[BCD_W-2:0], bin_q[W_IN-1]};
    assign ovf_next   = ovf_int_q | carry_out;
    assign last_shift = (state_q == S_SHIFT) && (cnt_q == '0);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        bin_d     = bin_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
`ifdef BCD_BLANK_EN
        blank_d   = blank_q;
`endif
        if (state_q == S_IDLE && i_start) begin
            bin_d     = i_bin;
            scr_d     = '0;
            cnt_d     = CNT_LAST;
            ovf_int_d = 1'b0;
        end else if (state_q == S_SHIFT) begin
            bin_d     = {bin_q[W_IN-2:0], 1'b0};
            scr_d     = scr_shift;
            ovf_int_d = ovf_next;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        // Result registers load on the edge entering DONE so they appear with o_done.
        if (last_shift) begin
            bcd_d   = ovf_next ? all_nines : scr_shift;
            ovf_d   = ovf_next;
`ifdef BCD_BLANK_EN
            blank_d = ovf_next ? '0 : blank_of(scr_shift);
`endif
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
`ifdef BCD_BLANK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    // Output logic
    always_comb begin
        o_busy      = (state_q == S_SHIFT);
        o_done      = (state_q == S_DONE);
        o_dbg_state = state_q;
        o_bcd       = bcd_q;
        o_ovf       = ovf_q;
`ifdef BCD_BLANK_EN
        o_blank     = blank_q;
`endif
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a default 16-bit/5-digit instance and an 8-bit/2-digit instance
// checked against a decimal arithmetic reference model.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;

    logic        start_a;
    logic [15:0] bin_a;
    logic        busy_a, done_a, ovf_a;
    logic [19:0] bcd_a;
    logic [1:0]  st_a;

    logic        start_b;
    logic [7:0]  bin_b;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [1:0]  st_b;

`ifdef BCD_BLANK_EN
    logic [4:0]  blank_a;
    logic [1:0]  blank_b;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [19:0] exp_q[$];

    bin2bcd_seq #(.W_IN(16), .N_DIGITS(5)) u_dut_a (
        .i_clock(clk), .i_reset(rst), .i_start(start_a), .i_bin(bin_a),
        .o_busy(busy_a), .o_done(done_a), .o_bcd(bcd_a), .o_ovf(ovf_a),
`ifdef BCD_BLANK_EN
        .o_blank(blank_a),
`endif
        .o_dbg_state(st_a)
    );

    bin2bcd_seq #(.W_IN(8), .N_DIGITS(2)) u_dut_b (
        .i_clock(clk), .i_reset(rst), .i_start(start_b), .i_bin(bin_b),
        .o_busy(busy_b), .o_done(done_b), .o_bcd(bcd_b), .o_ovf(ovf_b),
`ifdef BCD_BLANK_EN
        .o_blank(blank_b),
`endif
        .o_dbg_state(st_b)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    // Reference model: decimal digits by division; saturate to all nines when too large.
    function automatic logic [19:0] model_bcd(input int unsigned v, input int n);
        int unsigned lim = 1;
        int unsigned p = 1;
        logic [19:0] r = '0;
        for (int k = 0; k < n; k++) lim = lim * 10;
        for (int k = 0; k < n; k++) begin
            r[4*k +: 4] = (v >= lim) ? 4'd9 : 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int unsigned v, input int n);
        int unsigned lim = 1;
        for (int k = 0; k < n; k++) lim = lim * 10;
        return v >= lim;
    endfunction

    function automatic logic [4:0] model_blank(input int unsigned v, input int n);
        int unsigned p = 10;
        logic [4:0] r = '0;
        if (model_ovf(v, n)) return '0;
        for (int k = 1; k < n; k++) begin
            r[k] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    // Driver tasks: one start pulse, then wait (bounded) for o_done; lat = cycles after start edge.
    task automatic conv_a(input logic [15:0] v, output logic [19:0] bcd, output logic ovf,
                          output int lat);
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = v;
        @(negedge clk);
        start_a = 1'b0;
        bin_a   = 16'($urandom);
        lat = 1;
        while (done_a !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        bcd = bcd_a;
        ovf = ovf_a;
    endtask

    task automatic conv_b(input logic [7:0] v, output logic [7:0] bcd, output logic ovf,
                          output int lat);
        @(negedge clk);
        start_b = 1'b1;
        bin_b   = v;
        @(negedge clk);
        start_b = 1'b0;
        bin_b   = 8'($urandom);
        lat = 1;
        while (done_b !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        bcd = bcd_b;
        ovf = ovf_b;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({busy_a, done_a, bcd_a, ovf_a} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_a: got busy=%b done=%b bcd=%h ovf=%b, want all 0",
                     busy_a, done_a, bcd_a, ovf_a);
        end
        n_cmp++;
        if ({busy_b, done_b, bcd_b, ovf_b} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_b: got busy=%b done=%b bcd=%h ovf=%b, want all 0",
                     busy_b, done_b, bcd_b, ovf_b);
        end
`ifdef BCD_BLANK_EN
        n_cmp++;
        if ({blank_a, blank_b} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_blank: got a=%b b=%b, want 0", blank_a, blank_b);
        end
`endif
    endtask

    task automatic test_directed();
        logic [15:0] va[3] = '{16'd65535, 16'd0, 16'd1234};
        logic [19:0] ea[3] = '{20'h65535, 20'h00000, 20'h01234};
        logic [7:0]  vb[4] = '{8'd57, 8'd100, 8'd99, 8'd255};
        logic [7:0]  eb[4] = '{8'h57, 8'h99, 8'h99, 8'h99};
        logic        ob[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [19:0] gbcd;
        logic [7:0]  gb;
        logic        govf;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            conv_a(va[i], gbcd, govf, lat);
            n_cmp++;
            if (lat != 17 || gbcd !== ea[i] || govf !== 1'b0) begin
                n_err++;
                $display("FAIL directed_a[%0d]: got lat=%0d bcd=%h ovf=%b, want lat=17 bcd=%h ovf=0",
                         i, lat, gbcd, govf, ea[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            conv_b(vb[i], gb, govf, lat);
            n_cmp++;
            if (lat != 9 || gb !== eb[i] || govf !== ob[i]) begin
                n_err++;
                $display("FAIL directed_b[%0d]: got lat=%0d bcd=%h ovf=%b, want lat=9 bcd=%h ovf=%b",
                         i, lat, gb, govf, eb[i], ob[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [19:0] gbcd, exp;
        logic [7:0]  gb;
        logic        govf;
        int          lat;
        int unsigned v;
        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(0, 65535);
            exp_q.push_back(model_bcd(v, 5));
            conv_a(16'(v), gbcd, govf, lat);
            exp = exp_q.pop_front();
            n_cmp++;
            if (lat != 17 || gbcd !== exp || govf !== 1'b0) begin
                n_err++;
                $display("FAIL random_a v=%0d: got lat=%0d bcd=%h ovf=%b, want lat=17 bcd=%h ovf=0",
                         v, lat, gbcd, govf, exp);
            end
        end
        for (int i = 0; i < 25; i++) begin
            v = $urandom_range(0, 255);
            exp_q.push_back(model_bcd(v, 2));
            conv_b(8'(v), gb, govf, lat);
            exp = exp_q.pop_front();
            n_cmp++;
            if (lat != 9 || gb !== exp[7:0] || govf !== model_ovf(v, 2)) begin
                n_err++;
                $display("FAIL random_b v=%0d: got lat=%0d bcd=%h ovf=%b, want lat=9 bcd=%h ovf=%b",
                         v, lat, gb, govf, exp[7:0], model_ovf(v, 2));
            end
        end
    endtask

    task automatic test_hold_and_ignore();
        logic [19:0] exp;
        int lat;
        int extra_done;
        // start ignored while busy: first operand must win
        exp = model_bcd(111, 5);
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 16'd111;
        @(negedge clk);
        start_a = 1'b0;
        lat = 1;
        while (done_a !== 1'b1 && lat < 60) begin
            if (lat == 3) begin
                start_a = 1'b1;
                bin_a   = 16'd999;
            end else begin
                start_a = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 17 || bcd_a !== exp) begin
            n_err++;
            $display("FAIL ignore_busy: got lat=%0d bcd=%h, want lat=17 bcd=%h", lat, bcd_a, exp);
        end
        // start during DONE also ignored, outputs hold
        start_a = 1'b1;
        bin_a   = 16'd888;
        @(negedge clk);
        start_a = 1'b0;
        extra_done = 0;
        for (int t = 0; t < 20; t++) begin
            if (done_a === 1'b1 || busy_a === 1'b1) extra_done++;
            @(negedge clk);
        end
        n_cmp++;
        if (extra_done != 0 || bcd_a !== exp || ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_done_hold: got activity=%0d bcd=%h ovf=%b, want 0 %h 0",
                     extra_done, bcd_a, ovf_a, exp);
        end
    endtask

    task automatic test_back_to_back();
        int bad_timing = 0;
        int bad_val = 0;
        int dones = 0;
        int ph;
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 16'd1234;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            ph = t % 18;
            if (busy_a !== (ph >= 1 && ph <= 16) || done_a !== (ph == 17)) bad_timing++;
            if (done_a === 1'b1) begin
                dones++;
                if (bcd_a !== 20'h01234) bad_val++;
            end
        end
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bad_timing != 0 || dones != 2) begin
            n_err++;
            $display("FAIL b2b_timing: got bad_cycles=%0d dones=%0d, want 0 and 2", bad_timing, dones);
        end
        n_cmp++;
        if (bad_val != 0) begin
            n_err++;
            $display("FAIL b2b_value: got %0d wrong results, want 0", bad_val);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] gbcd;
        logic        govf;
        int          lat;
        int          dones = 0;
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 16'd500;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || bcd_a !== 20'h0 || ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b bcd=%h ovf=%b, want 0 0 0 0",
                     busy_a, done_a, bcd_a, ovf_a);
        end
        for (int t = 0; t < 25; t++) begin
            if (done_a === 1'b1) dones++;
            @(negedge clk);
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL reset_mid_nodone: got %0d done pulses, want 0", dones);
        end
        conv_a(16'd7, gbcd, govf, lat);
        n_cmp++;
        if (lat != 17 || gbcd !== 20'h00007 || govf !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset: got lat=%0d bcd=%h ovf=%b, want 17 00007 0", lat, gbcd, govf);
        end
    endtask

`ifdef BCD_BLANK_EN
    task automatic test_blank();
        logic [15:0] va[4] = '{16'd42, 16'd0, 16'd10000, 16'd305};
        logic [19:0] gbcd;
        logic [7:0]  gb;
        logic [4:0]  eb;
        logic        govf;
        int          lat;
        int unsigned v;
        for (int i = 0; i < 4; i++) begin
            eb = model_blank(va[i], 5);
            conv_a(va[i], gbcd, govf, lat);
            n_cmp++;
            if (blank_a !== eb) begin
                n_err++;
                $display("FAIL blank_a v=%0d: got %b, want %b", va[i], blank_a, eb);
            end
        end
        for (int i = 0; i < 12; i++) begin
            v = $urandom_range(0, 255);
            eb = model_blank(v, 2);
            conv_b(8'(v), gb, govf, lat);
            n_cmp++;
            if (blank_b !== eb[1:0]) begin
                n_err++;
                $display("FAIL blank_b v=%0d: got %b, want %b", v, blank_b, eb[1:0]);
            end
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        bin_a   = '0;
        start_b = 1'b0;
        bin_b   = '0;
        test_reset();
        test_directed();
        test_random();
        test_hold_and_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef BCD_BLANK_EN
        test_blank();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
